vx_tcu_sequencer: RTL and testbench
===================================

VX_TCU_SEQUENCER -- requirements
Module: VX_tcu_sequencer

Interface
REQ-001 Parameter TILE_ELEMS, default 4, elements per operand/result tile; SHALL be a power of 2, minimum 2.
REQ-002 Parameter DATAW, default 32, element width in bits.
REQ-003 Parameter TAG_WIDTH, default 8, request tag width.
REQ-004 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-005 reset  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  1  tile-operation request.
REQ-007 req_ready  out  1  sequencer idle and accepting.
REQ-008 req_tag  in  TAG_WIDTH  request identifier.
REQ-009 csr_rd_en  out  1  operand CSR read strobe.
REQ-010 csr_rd_idx  out  log2(TILE_ELEMS)  operand element index.
REQ-011 csr_rd_data_a  in  DATAW  A element, valid 1 cycle after csr_rd_en.
REQ-012 csr_rd_data_b  in  DATAW  B element, valid 1 cycle after csr_rd_en.
REQ-013 tu_load_valid  out  1  operand beat to tensor unit.
REQ-014 tu_data_a  out  DATAW  A operand beat.
REQ-015 tu_data_b  out  DATAW  B operand beat.
REQ-016 tu_exec_start  out  1  single-cycle multiply start pulse.
REQ-017 tu_exec_done  in  1  multiply complete.
REQ-018 tu_store_en  out  1  tensor unit shall present next C element.
REQ-019 tu_data_c  in  DATAW  C element, same cycle as tu_store_en.
REQ-020 csr_wr_en  out  1  result CSR write strobe.
REQ-021 csr_wr_idx  out  log2(TILE_ELEMS)  result element index.
REQ-022 csr_wr_data  out  DATAW  result element.
REQ-023 rsp_valid  out  1  operation complete.
REQ-024 rsp_ready  in  1  response consumed.
REQ-025 rsp_tag  out  TAG_WIDTH  tag of completed request.
REQ-026 rsp_error  out  1  operation aborted.

Function
REQ-027 States IDLE, LOAD, EXEC, STORE, RESP; one index counter idx shared by LOAD and STORE.
REQ-028 IDLE: req_ready=1; req_valid&&req_ready SHALL latch req_tag, clear idx, enter LOAD; other states: req_ready=0, requests ignored.
REQ-029 LOAD: cycles 0..TILE_ELEMS-1 assert csr_rd_en with csr_rd_idx=idx, idx+1 per cycle; cycles 1..TILE_ELEMS assert tu_load_valid with tu_data_a/b = registered csr_rd_data_a/b of prior cycle; LOAD lasts exactly TILE_ELEMS+1 cycles.
REQ-030 EXEC: tu_exec_start=1 in first EXEC cycle only; tu_exec_done sampled from the following cycle; done in the start cycle SHALL be ignored; done -> STORE with idx=0.
REQ-031 STORE: TILE_ELEMS cycles, each asserting tu_store_en and csr_wr_en with csr_wr_idx=idx, csr_wr_data=tu_data_c; after idx=TILE_ELEMS-1 wrap idx to 0, enter RESP.
REQ-032 RESP: rsp_valid=1, rsp_tag=latched tag; rsp_tag/rsp_error SHALL hold stable until rsp_ready; rsp_valid&&rsp_ready -> IDLE, next request acceptable the cycle after.
REQ-033 Latency with TILE_ELEMS=4 and done on first sampled cycle: accept to rsp_valid = 5+2+4 = 11 cycles.
REQ-034 csr_rd_en, tu_load_valid, csr_wr_en never asserted outside LOAD/STORE; at most one operation in flight.

Reset
REQ-035 reset=0 SHALL force IDLE, idx=0, all outputs 0 except req_ready=1 on the following cycle.
REQ-036 reset mid-operation SHALL abort with no further CSR write and no response.

Configuration
REQ-037 TCU_SEQ_TIMEOUT_EN defined: 8-bit counter runs in EXEC; 255 cycles after tu_exec_start without done -> RESP with rsp_error=1, STORE skipped, no CSR writes.
REQ-038 TCU_SEQ_TIMEOUT_EN undefined: no counter, EXEC waits indefinitely, rsp_error constant 0.

Verification
REQ-039 req tag 0x5A, CSR A=[1,2,3,4], B=[5,6,7,8], done 3 cycles after start -> beats (1,5)..(4,8), writes idx 0..3, rsp_tag 0x5A.
REQ-040 req_valid held during busy with tag 0x11 -> req_ready=0, no capture until RESP handshake.
REQ-041 rsp_ready low 10 cycles -> rsp_valid, rsp_tag stable 10 cycles, single handshake.
REQ-042 reset=0 during STORE idx=2 -> no further csr_wr_en, no rsp_valid, req_ready=1 next cycle.
REQ-043 TCU_SEQ_TIMEOUT_EN, done never asserted -> rsp_valid with rsp_error=1 exactly 256 cycles after EXEC entry, zero CSR writes.

Source files
------------

// File: rtl/vx_tcu_sequencer.sv
// vx_tcu_sequencer: steps one tile operation through operand load, tensor-unit
// execute, result store and response handshake, one operation at a time.
// Optional build macro: TCU_SEQ_TIMEOUT_EN adds an 8-bit EXEC watchdog that
// aborts the operation with rsp_error=1 when tu_exec_done never arrives.
// TILE_ELEMS must be a power of two and at least 2 so that idx wraps cleanly.
module vx_tcu_sequencer #(
    parameter int TILE_ELEMS = 4,
    parameter int DATAW      = 32,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [TAG_WIDTH-1:0]          req_tag,

    output logic                          csr_rd_en,
    output logic [$clog2(TILE_ELEMS)-1:0] csr_rd_idx,
    input  logic [DATAW-1:0]              csr_rd_data_a,
    input  logic [DATAW-1:0]              csr_rd_data_b,

    output logic                          tu_load_valid,
    output logic [DATAW-1:0]              tu_data_a,
    output logic [DATAW-1:0]              tu_data_b,
    output logic                          tu_exec_start,
    input  logic                          tu_exec_done,
    output logic                          tu_store_en,
    input  logic [DATAW-1:0]              tu_data_c,

    output logic                          csr_wr_en,
    output logic [$clog2(TILE_ELEMS)-1:0] csr_wr_idx,
    output logic [DATAW-1:0]              csr_wr_data,

    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [TAG_WIDTH-1:0]          rsp_tag,
    output logic                          rsp_error
);

    localparam int IDXW = $clog2(TILE_ELEMS);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(TILE_ELEMS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_STORE = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    // Element index shared by the LOAD read stream and the STORE write stream.
    logic [IDXW-1:0]        idx_q, idx_d;
    // Set once all reads are issued: the extra LOAD cycle that forwards the last beat.
    logic                   load_tail_q, load_tail_d;
    // Marks the first EXEC cycle, where the start pulse fires and done is ignored.
    logic                   exec_first_q, exec_first_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
`ifdef TCU_SEQ_TIMEOUT_EN
    logic [7:0]             timer_q, timer_d;
    logic                   err_q, err_d;
`endif

    // Next-state and output decode; every output is zero unless its state drives it.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        load_tail_d  = load_tail_q;
        exec_first_d = exec_first_q;
        tag_d        = tag_q;
`ifdef TCU_SEQ_TIMEOUT_EN
        timer_d      = timer_q;
        err_d        = err_q;
`endif

        req_ready     = 1'b0;
        csr_rd_en     = 1'b0;
        csr_rd_idx    = '0;
        tu_load_valid = 1'b0;
        tu_data_a     = '0;
        tu_data_b     = '0;
        tu_exec_start = 1'b0;
        tu_store_en   = 1'b0;
        csr_wr_en     = 1'b0;
        csr_wr_idx    = '0;
        csr_wr_data   = '0;
        rsp_valid     = 1'b0;
        rsp_tag       = '0;
        rsp_error     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    tag_d       = req_tag;
                    idx_d       = '0;
                    load_tail_d = 1'b0;
`ifdef TCU_SEQ_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                    state_d     = ST_LOAD;
                end
            end

            ST_LOAD: begin
                // Issue one CSR read per cycle until every element is requested.
                if (!load_tail_q) begin
                    csr_rd_en  = 1'b1;
                    csr_rd_idx = idx_q;
                    if (idx_q == IDX_LAST) begin
                        idx_d       = '0;
                        load_tail_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                // CSR data arrives one cycle after its read, so beats trail reads by one.
                if (load_tail_q || (idx_q != '0)) begin
                    tu_load_valid = 1'b1;
                    tu_data_a     = csr_rd_data_a;
                    tu_data_b     = csr_rd_data_b;
                end
                if (load_tail_q) begin
                    load_tail_d  = 1'b0;
                    exec_first_d = 1'b1;
`ifdef TCU_SEQ_TIMEOUT_EN
                    timer_d      = '0;
`endif
                    state_d      = ST_EXEC;
                end
            end

            ST_EXEC: begin
`ifdef TCU_SEQ_TIMEOUT_EN
                timer_d = timer_q + 8'd1;
`endif
                if (exec_first_q) begin
                    tu_exec_start = 1'b1;
                    exec_first_d  = 1'b0;
                end else if (tu_exec_done) begin
                    idx_d   = '0;
                    state_d = ST_STORE;
                end
`ifdef TCU_SEQ_TIMEOUT_EN
                else if (timer_q == 8'hFF) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
`endif
            end

            ST_STORE: begin
                tu_store_en = 1'b1;
                csr_wr_en   = 1'b1;
                csr_wr_idx  = idx_q;
                csr_wr_data = tu_data_c;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_tag   = tag_q;
`ifdef TCU_SEQ_TIMEOUT_EN
                rsp_error = err_q;
`endif
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset that abandons any operation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            load_tail_q  <= 1'b0;
            exec_first_q <= 1'b0;
            tag_q        <= '0;
`ifdef TCU_SEQ_TIMEOUT_EN
            timer_q      <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            load_tail_q  <= load_tail_d;
            exec_first_q <= exec_first_d;
            tag_q        <= tag_d;
`ifdef TCU_SEQ_TIMEOUT_EN
            timer_q      <= timer_d;
            err_q        <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_vx_tcu_sequencer.sv
// Testbench for vx_tcu_sequencer: acts as operand CSR file, tensor unit and
// response consumer, and checks each operation against timing and data
// expectations derived from the sequencing rules.
module tb_vx_tcu_sequencer;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 8;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [TW-1:0] req_tag = '0;
    logic          csr_rd_en;
    logic [IW-1:0] csr_rd_idx;
    logic [DW-1:0] csr_rd_data_a = '0;
    logic [DW-1:0] csr_rd_data_b = '0;
    logic          tu_load_valid;
    logic [DW-1:0] tu_data_a;
    logic [DW-1:0] tu_data_b;
    logic          tu_exec_start;
    logic          tu_exec_done = 1'b0;
    logic          tu_store_en;
    logic [DW-1:0] tu_data_c = '0;
    logic          csr_wr_en;
    logic [IW-1:0] csr_wr_idx;
    logic [DW-1:0] csr_wr_data;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [TW-1:0] rsp_tag;
    logic          rsp_error;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] mem_a [N];
    logic [DW-1:0] mem_b [N];
    logic [DW-1:0] mem_c [N];

    vx_tcu_sequencer #(.TILE_ELEMS(N), .DATAW(DW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
        .csr_rd_en(csr_rd_en), .csr_rd_idx(csr_rd_idx),
        .csr_rd_data_a(csr_rd_data_a), .csr_rd_data_b(csr_rd_data_b),
        .tu_load_valid(tu_load_valid), .tu_data_a(tu_data_a), .tu_data_b(tu_data_b),
        .tu_exec_start(tu_exec_start), .tu_exec_done(tu_exec_done),
        .tu_store_en(tu_store_en), .tu_data_c(tu_data_c),
        .csr_wr_en(csr_wr_en), .csr_wr_idx(csr_wr_idx), .csr_wr_data(csr_wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
        .rsp_error(rsp_error)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    task automatic fillOperands(input bit fixed);
        for (int k = 0; k < N; k++) begin
            if (fixed) begin
                mem_a[k] = DW'(k + 1);
                mem_b[k] = DW'(k + 5);
                mem_c[k] = DW'(32'hC0 + k);
            end else begin
                mem_a[k] = $urandom;
                mem_b[k] = $urandom;
                mem_c[k] = $urandom;
            end
        end
    endtask

    // done_dly: 0 = done held high for the whole operation (even in the start cycle),
    // k>0 = done raised k cycles after the start pulse, -1 = done never raised.
    // rsp_dly: cycles rsp_ready stays low after rsp_valid appears (0 = ready held high).
    // busy_req: keep req_valid high with tag 0x11 while the operation is in flight.
    // abort_idx: pull reset low in the cycle that writes this index (-1 = no reset).
    task automatic applyStimulus(input logic [TW-1:0] tag, input int done_dly,
                                 input int rsp_dly, input bit busy_req,
                                 input int abort_idx);
        int c, rd_cnt, beat_cnt, wr_cnt, start_cnt, start_cyc, rsp_cyc;
        int hs_cnt, hold_cnt, post;
        int rd_err, beat_err, wr_err, busy_err, stab_err, post_err;
        int exec_len, store_base, exp_rsp, exp_wr;
        bit exp_err, finished, aborted, rd_pend;
        logic [IW-1:0] rd_pend_idx;
        logic [TW-1:0] first_tag;
        logic          first_err;

        rd_cnt = 0; beat_cnt = 0; wr_cnt = 0; start_cnt = 0; start_cyc = 0;
        rsp_cyc = 0; hs_cnt = 0; hold_cnt = 0; post = 0;
        rd_err = 0; beat_err = 0; wr_err = 0; busy_err = 0; stab_err = 0; post_err = 0;
        finished = 0; aborted = 0; rd_pend = 0; rd_pend_idx = '0;
        first_tag = '0; first_err = 1'b0;

        if (done_dly == 0)     exec_len = 2;
        else if (done_dly > 0) exec_len = done_dly + 1;
        else                   exec_len = 256;
        exp_err    = (done_dly < 0);
        store_base = 1 + (N + 1) + exec_len;
        exp_rsp    = store_base + (exp_err ? 0 : N);
        exp_wr     = exp_err ? 0 : N;
        if (abort_idx >= 0) exp_wr = abort_idx + 1;

        c = 0;
        while (req_ready !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        checkOutput("idle_ready", 64'(req_ready), 64'(1));

        req_valid    = 1'b1;
        req_tag      = tag;
        rsp_ready    = (rsp_dly == 0);
        tu_exec_done = (done_dly == 0);

        c = 0;
        while (!finished && c < 1000) begin
            @(posedge clk);
            #1;
            c++;
            if (c == 1) begin
                if (busy_req) req_tag = 8'h11;
                else          req_valid = 1'b0;
            end
            csr_rd_data_a = rd_pend ? mem_a[rd_pend_idx] : $urandom;
            csr_rd_data_b = rd_pend ? mem_b[rd_pend_idx] : $urandom;
            tu_data_c     = (wr_cnt < N) ? mem_c[wr_cnt] : $urandom;
            if (done_dly > 0 && start_cnt > 0 && c >= start_cyc + done_dly)
                tu_exec_done = 1'b1;
            if (rsp_dly > 0 && rsp_cyc > 0 && c >= rsp_cyc + rsp_dly)
                rsp_ready = 1'b1;
            if (aborted) begin
                reset = 1'b1;
                post++;
            end

            @(negedge clk);
            rd_pend     = csr_rd_en;
            rd_pend_idx = csr_rd_idx;
            if (aborted) begin
                if (csr_wr_en || tu_store_en || rsp_valid || csr_rd_en || tu_load_valid ||
                    tu_exec_start || req_ready !== 1'b1)
                    post_err++;
                if (post >= 20) finished = 1;
            end else begin
                if (req_ready) busy_err++;
                if (csr_rd_en) begin
                    if (int'(csr_rd_idx) != rd_cnt || c != rd_cnt + 1) rd_err++;
                    rd_cnt++;
                end
                if (tu_load_valid) begin
                    if (beat_cnt >= N) beat_err++;
                    else if (tu_data_a !== mem_a[beat_cnt] || tu_data_b !== mem_b[beat_cnt] ||
                             c != beat_cnt + 2) beat_err++;
                    beat_cnt++;
                end
                if (tu_exec_start) begin
                    start_cnt++;
                    if (start_cnt == 1) start_cyc = c;
                end
                if (tu_store_en != csr_wr_en) wr_err++;
                if (csr_wr_en) begin
                    if (wr_cnt >= N) wr_err++;
                    else if (int'(csr_wr_idx) != wr_cnt || csr_wr_data !== mem_c[wr_cnt] ||
                             c != store_base + wr_cnt) wr_err++;
                    wr_cnt++;
                    if (abort_idx >= 0 && wr_cnt == abort_idx + 1) begin
                        reset   = 1'b0;
                        aborted = 1;
                    end
                end
                if (rsp_valid) begin
                    if (rsp_cyc == 0) begin
                        rsp_cyc   = c;
                        first_tag = rsp_tag;
                        first_err = rsp_error;
                    end else if (rsp_tag !== first_tag || rsp_error !== first_err) begin
                        stab_err++;
                    end
                    if (rsp_ready) begin
                        hs_cnt++;
                        finished = 1;
                    end else begin
                        hold_cnt++;
                    end
                end
            end
        end
        checkOutput("op_budget", 64'(finished), 64'(1));

        if (abort_idx >= 0) begin
            req_valid = 1'b0; rsp_ready = 1'b0; tu_exec_done = 1'b0;
            checkOutput("abort_wr_count", 64'(wr_cnt), 64'(exp_wr));
            checkOutput("abort_wr_err", 64'(wr_err), 64'(0));
            checkOutput("abort_post_err", 64'(post_err), 64'(0));
            checkOutput("abort_no_rsp", 64'(rsp_cyc), 64'(0));
        end else begin
            @(posedge clk);
            #1;
            req_valid = 1'b0; rsp_ready = 1'b0; tu_exec_done = 1'b0;
            @(negedge clk);
            checkOutput("ready_after_rsp", 64'(req_ready), 64'(1));
            checkOutput("rsp_gone", 64'(rsp_valid), 64'(0));
            checkOutput("rd_count", 64'(rd_cnt), 64'(N));
            checkOutput("rd_err", 64'(rd_err), 64'(0));
            checkOutput("beat_count", 64'(beat_cnt), 64'(N));
            checkOutput("beat_err", 64'(beat_err), 64'(0));
            checkOutput("start_count", 64'(start_cnt), 64'(1));
            checkOutput("start_cycle", 64'(start_cyc), 64'(N + 2));
            checkOutput("wr_count", 64'(wr_cnt), 64'(exp_wr));
            checkOutput("wr_err", 64'(wr_err), 64'(0));
            checkOutput("rsp_cycle", 64'(rsp_cyc), 64'(exp_rsp));
            checkOutput("rsp_tag", 64'(first_tag), 64'(tag));
            checkOutput("rsp_error", 64'(first_err), 64'(exp_err));
            checkOutput("rsp_stable", 64'(stab_err), 64'(0));
            checkOutput("rsp_hold", 64'(hold_cnt), 64'(rsp_dly));
            checkOutput("handshakes", 64'(hs_cnt), 64'(1));
            checkOutput("busy_ready", 64'(busy_err), 64'(0));
        end
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ready", 64'(req_ready), 64'(1));
        checkOutput("reset_outputs_zero",
                    64'(|{csr_rd_en, csr_rd_idx, tu_load_valid, tu_data_a, tu_data_b,
                          tu_exec_start, tu_store_en, csr_wr_en, csr_wr_idx, csr_wr_data,
                          rsp_valid, rsp_tag, rsp_error}), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        checkOutput("idle_after_reset", 64'(req_ready), 64'(1));

        $display("[TB] directed: tag 0x5A, operands 1..4 / 5..8, done 3 cycles after start");
        fillOperands(1);
        applyStimulus(8'h5A, 3, 0, 0, -1);

        $display("[TB] directed: done held high from the start cycle, 11-cycle latency");
        fillOperands(1);
        applyStimulus(8'h3C, 0, 0, 0, -1);

        $display("[TB] directed: request held with tag 0x11 while busy");
        fillOperands(0);
        applyStimulus(8'h77, 2, 0, 1, -1);

        $display("[TB] directed: rsp_ready low for 10 cycles");
        fillOperands(0);
        applyStimulus(8'hA5, 1, 10, 0, -1);

        $display("[TB] directed: reset during STORE at idx 2");
        fillOperands(0);
        applyStimulus(8'h42, 2, 0, 0, 2);

        $display("[TB] directed: operation after mid-flight reset");
        fillOperands(0);
        applyStimulus(8'h99, 0, 0, 0, -1);

        $display("[TB] random operations");
        for (int i = 0; i < 6; i++) begin
            fillOperands(0);
            applyStimulus(TW'($urandom), int'($urandom_range(1, 6)),
                          int'($urandom_range(0, 4)), 1'b0, -1);
        end

`ifdef TCU_SEQ_TIMEOUT_EN
        $display("[TB] directed: done never arrives, watchdog abort");
        fillOperands(0);
        applyStimulus(8'hE1, -1, 2, 0, -1);
`else
        $display("[TB] directed: late done, EXEC waits without a watchdog");
        fillOperands(0);
        applyStimulus(8'hE1, 300, 2, 0, -1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
